// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-client main-memory arbiter.
package mem_arb_pkg;
  localparam int MEM_ADDR_W = 28;
  localparam int MEM_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic CLI_I = 1'b0;
  localparam logic CLI_D = 1'b1;
endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker; a tie goes to the client not served last.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       vld
);
  always_comb begin
    vld = |req;
    gnt = CLI_I;
    if (req == 2'b11) gnt = ~last;
    else if (req[CLI_D]) gnt = CLI_D;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache/dcache block transactions onto one memory port; 3 cycles of overhead
// beyond memory latency, requests are held by clients until their one-cycle ready pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] c_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state;
  logic   last_grant;
  logic   grant;
  logic   pick_gnt;
  logic   pick_vld;

  arb_rr2 u_rr (
    .req  ({d_read | d_write, i_read}),
    .last (last_grant),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  always_ff @(posedge clk or negedge proc_reset) begin
    if (!proc_reset) begin
      state      <= IDLE;
      last_grant <= CLI_I;
      grant      <= CLI_I;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      c_rdata    <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick_gnt;
            state <= BUSY;
            // A combined dcache read+write issues the write-back; the read stays pending.
            if (pick_gnt == CLI_D) begin
              mem_write <= d_write;
              mem_read  <= ~d_write;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= i_addr;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            if (mem_read) c_rdata <= mem_rdata;
            i_ready    <= (grant == CLI_I);
            d_ready    <= (grant == CLI_D);
            last_grant <= grant;
            state      <= DONE;
          end
        end
        // Dead cycle: the served client is still dropping its request.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model and directed checks.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_read, d_read, d_write, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] c_rdata, mem_wdata;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  mem_arbiter dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .c_rdata(c_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, a completion blocks new grants for one
  // extra edge, ties go to the client not served last (dcache first after reset).
  bit          m_active, m_skip, m_gnt, m_last;
  bit          e_ir, e_dr, e_mr, e_mw;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rd;

  function automatic bit pick_d(input bit ireq, input bit dreq, input bit last_d);
    if (ireq && dreq) return !last_d;
    return dreq;
  endfunction

  always @(posedge clk or negedge proc_reset) begin
    if (!proc_reset) begin
      m_active <= 0; m_skip <= 0; m_gnt <= 0; m_last <= 0;
      e_ir <= 0; e_dr <= 0; e_mr <= 0; e_mw <= 0;
      e_addr <= '0; e_wd <= '0; e_rd <= '0;
    end else begin
      e_ir <= 0;
      e_dr <= 0;
      if (m_active) begin
        if (mem_ready) begin
          if (e_mr) e_rd <= mem_rdata;
          e_ir <= !m_gnt;
          e_dr <= m_gnt;
          m_last <= m_gnt;
          e_mr <= 0; e_mw <= 0;
          m_active <= 0;
          m_skip <= 1;
        end
      end else if (m_skip) begin
        m_skip <= 0;
      end else if (i_read || d_read || d_write) begin
        m_active <= 1;
        if (pick_d(i_read, d_read || d_write, m_last)) begin
          m_gnt <= 1;
          e_mw <= d_write;
          e_mr <= !d_write;
          e_addr <= d_addr;
          e_wd <= d_wdata;
        end else begin
          m_gnt <= 0;
          e_mr <= 1;
          e_addr <= i_addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("i_ready", i_ready, e_ir);
      chk("d_ready", d_ready, e_dr);
      chk("c_rdata", c_rdata, e_rd);
      chk("mem_read", mem_read, e_mr);
      chk("mem_write", mem_write, e_mw);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
    end
  end

  // Waits for a memory command, answers after lat cycles, returns when ready is visible.
  task automatic serve(input int lat, input logic [DW-1:0] data);
    int n = 0;
    while (!(mem_read || mem_write) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL serve_timeout: no memory command after %0d cycles, expected one", n);
    end
    repeat (lat - 1) @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  logic [DW-1:0] a5, w1234, saved;
  bit            busy_mem;
  int            cnt;

  initial begin
    a5 = {16{8'hA5}};
    w1234 = {8{16'h1234}};
    i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    proc_reset = 1'b1;
    #1 proc_reset = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    proc_reset = 1'b1;

    // Single icache read, memory answers in the 4th busy cycle
    @(negedge clk);
    i_read = 1; i_addr = 28'h0000010;
    @(negedge clk);
    chk("t1_mem_read", mem_read, 1);
    chk("t1_mem_addr", mem_addr, 28'h10);
    repeat (3) @(negedge clk);
    mem_ready = 1; mem_rdata = a5;
    @(negedge clk);
    mem_ready = 0;
    chk("t1_i_ready", i_ready, 1);
    chk("t1_c_rdata", c_rdata, a5);
    chk("t1_d_ready", d_ready, 0);
    i_read = 0;
    @(negedge clk);
    chk("t1_i_ready_pulse", i_ready, 0);

    // Tie right after reset: dcache first, then icache
    proc_reset = 0;
    @(negedge clk);
    proc_reset = 1;
    i_read = 1; i_addr = 28'h40; d_read = 1; d_addr = 28'h50;
    serve(2, {4{32'h11111111}});
    chk("tie1_d_ready", d_ready, 1);
    chk("tie1_mem_addr", mem_addr, 28'h50);
    d_read = 0;
    serve(2, {4{32'h22222222}});
    chk("tie1_i_ready", i_ready, 1);
    chk("tie1b_mem_addr", mem_addr, 28'h40);
    // Tie with last=I goes to D, then tie with last=D goes to I
    d_read = 1; d_addr = 28'h60;
    serve(1, {4{32'h33333333}});
    chk("tie2_d_ready", d_ready, 1);
    d_addr = 28'h70;
    serve(1, {4{32'h44444444}});
    chk("tie3_i_ready", i_ready, 1);
    chk("tie3_mem_addr", mem_addr, 28'h40);
    i_read = 0;
    serve(1, {4{32'h55555555}});
    chk("tie3_d_after", d_ready, 1);
    d_read = 0;

    // Write-back + read: write first, read later, write leaves c_rdata alone
    @(negedge clk);
    saved = c_rdata;
    d_write = 1; d_read = 1; d_addr = 28'h20; d_wdata = w1234;
    @(negedge clk);
    chk("wb_mem_write", mem_write, 1);
    chk("wb_mem_read", mem_read, 0);
    chk("wb_mem_wdata", mem_wdata, w1234);
    serve(2, {4{32'hDEADBEEF}});
    chk("wb_d_ready", d_ready, 1);
    chk("wb_c_rdata", c_rdata, saved);
    d_write = 0;
    @(negedge clk);
    @(negedge clk);
    chk("wb_rd_mem_read", mem_read, 1);
    chk("wb_rd_mem_write", mem_write, 0);
    serve(1, {4{32'hCAFEF00D}});
    chk("wb_rd_c_rdata", c_rdata, {4{32'hCAFEF00D}});
    d_read = 0;

    // Held icache request is not reissued before the dead cycle passes
    @(negedge clk);
    i_read = 1; i_addr = 28'h88;
    serve(1, a5);
    chk("hold_i_ready", i_ready, 1);
    @(negedge clk);
    chk("hold_no_reissue", mem_read, 0);
    @(negedge clk);
    chk("hold_reissue", mem_read, 1);
    serve(1, w1234);
    i_read = 0;

    // Spurious mem_ready in idle
    @(negedge clk);
    saved = c_rdata;
    mem_ready = 1; mem_rdata = {16{8'hFF}};
    @(negedge clk);
    mem_ready = 0;
    chk("spur_i_ready", i_ready, 0);
    chk("spur_d_ready", d_ready, 0);
    chk("spur_c_rdata", c_rdata, saved);

    // Reset in the middle of a read, then a stale completion
    i_read = 1; i_addr = 28'h30;
    @(negedge clk);
    chk("mid_mem_read", mem_read, 1);
    #2 proc_reset = 0;
    #1;
    chk("mid_rst_mem_read", mem_read, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_c_rdata", c_rdata, 0);
    @(negedge clk);
    i_read = 0; mem_ready = 1; mem_rdata = a5; proc_reset = 1;
    @(negedge clk);
    mem_ready = 0;
    chk("stale_i_ready", i_ready, 0);
    chk("stale_c_rdata", c_rdata, 0);
    i_read = 1; i_addr = 28'h44;
    serve(2, {4{32'h0BADF00D}});
    chk("post_rst_i_ready", i_ready, 1);
    chk("post_rst_c_rdata", c_rdata, {4{32'h0BADF00D}});
    i_read = 0;

    // Randomized traffic
    busy_mem = 0; cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        proc_reset = 0;
        i_read = 0; d_read = 0; d_write = 0; busy_mem = 0;
        mem_ready = 0;
        @(negedge clk);
        proc_reset = 1;
        mem_ready = $urandom_range(0, 1);
        mem_rdata = {4{$urandom}};
        continue;
      end
      if (mem_ready) begin
        mem_ready = 0;
        busy_mem = 0;
      end else begin
        if (!busy_mem && (mem_read || mem_write)) begin
          busy_mem = 1;
          cnt = $urandom_range(0, 3);
        end
        if (busy_mem) begin
          if (cnt == 0) begin
            mem_ready = 1;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
          end else cnt--;
        end else if ($urandom_range(0, 15) == 0) begin
          mem_ready = 1;
          mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      if (i_ready) i_read = 0;
      else if (!i_read && $urandom_range(0, 3) == 0) begin
        i_read = 1;
        i_addr = AW'($urandom);
      end
      if (d_ready) begin
        if (d_write) d_write = 0;
        else d_read = 0;
      end else if (!d_read && !d_write && $urandom_range(0, 3) == 0) begin
        cnt = cnt;
        case ($urandom_range(0, 2))
          0: d_read = 1;
          1: d_write = 1;
          default: begin d_read = 1; d_write = 1; end
        endcase
        d_addr = AW'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter that shares the single 128-bit main-memory port between the instruction-cache wrapper (read-only) and the data-cache wrapper (read/write-back). It sits between both cache wrappers and the memory model/controller. It serialises one block transaction at a time, registers all memory-facing outputs, and returns a registered one-cycle ready pulse plus read data to the granted client only.

## Interface

- ADDR_W, 28, block address width
- DATA_W, 128, block data width
- clk  in  1  single clock, rising edge
- proc_reset  in  1  asynchronous, active-low reset
- i_read  in  1  icache read request, held until i_ready
- i_addr  in  ADDR_W  icache block address
- i_ready  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache read request, held until d_ready
- d_write  in  1  dcache write-back request, held until d_ready
- d_addr  in  ADDR_W  dcache block address
- d_wdata  in  DATA_W  dcache write data
- d_ready  out  1  one-cycle completion pulse to dcache
- c_rdata  out  DATA_W  registered read data, shared by both clients, valid with i_ready/d_ready
- mem_read, mem_write  out  1  memory commands, registered
- mem_addr  out  ADDR_W, mem_wdata  out  DATA_W  registered
- mem_ready  in  1  memory completion, one cycle
- mem_rdata  in  DATA_W  valid with mem_ready

## Operation

- FSM with states IDLE, BUSY, DONE.
- IDLE: if any request is present, grant one client, latch its command/address/wdata into mem_* regs, and go to BUSY. With no request, stay.
- Arbitration on simultaneous i/d requests: grant the client not served last; last_grant resets to "I" so dcache wins the first tie. A single requester is granted regardless of last_grant.
- dcache with d_read and d_write both high: issue the write only. The read stays pending and is arbitrated afresh later.
- BUSY: hold mem_* stable. On mem_ready, clear mem_read/mem_write, pulse the granted client's ready, capture mem_rdata into c_rdata (reads only; c_rdata unchanged on writes), update last_grant, and go to DONE.
- DONE: one dead cycle. All requests are ignored, because the client drops its request only after seeing ready. Return to IDLE.
- mem_ready in IDLE/DONE is ignored, as is any stale completion after reset.
- Only one client's ready is ever high; ready is never high for two consecutive cycles.

## Timing

- Reset (async assert, sync deassert by the user): state=IDLE, last_grant=I, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, i_ready=d_ready=0, c_rdata=0.
- Request sampled high at edge k in IDLE: mem_read/mem_write visible from cycle k+1.
- mem_ready high in cycle j: at edge j mem_* drop and ready/c_rdata are set, so the client sees them in cycle j+1. Edge j+1 takes DONE to IDLE and clears ready. New requests are sampled from edge j+2.
- Arbiter overhead is 3 cycles per transaction beyond the memory latency (1 issue, 1 response register, 1 DONE).
- Request inputs are not required stable outside IDLE. Address and wdata are latched at grant.
- Reset mid-BUSY: outputs are cleared immediately and any in-flight memory response is dropped. Clients are reset by the same signal.

## Structure

- Shared package mem_arb_pkg holds:
  - state enum: IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - client IDs: CLI_I=1'b0, CLI_D=1'b1
  - ADDR_W/DATA_W defaults, matching the cache wrappers
- One natural sub-module, arb_rr2: a combinational 2-way round-robin picker (inputs req[1:0], last; output gnt id, valid). Everything else lives in mem_arbiter.

## Test plan

- Single icache read: i_read=1, i_addr=28'h0000010, memory ready after 4 cycles with rdata=128'hA5…A5 -> mem_read=1, mem_addr=28'h10 from next cycle; i_ready pulses exactly one cycle with c_rdata=A5…A5; d_ready stays 0.
- Simultaneous first requests: i_read and d_read both high after reset -> dcache served first, icache second. A later tie with last_grant=I goes to D; a tie with last_grant=D goes to I.
- dcache write-back then read: d_write=1, d_read=1, d_addr=28'h20, d_wdata=128'h1234… -> mem_write only, mem_wdata=1234…; then the read is issued in a separate transaction; c_rdata unchanged by the write.
- Held request not regranted: client keeps i_read high through the ready cycle -> no second mem_read until the DONE cycle has passed (earliest reissue is edge j+2).
- Spurious mem_ready in IDLE -> no ready pulse and no change to c_rdata.
- Reset asserted during BUSY with mem_read=1 -> all outputs 0 asynchronously; after release, the late mem_ready is ignored and a new i_read is served normally.
